// File: rtl/pulse_seq_multi.sv
// pulse_seq_multi: one period counter driving NCH programmable gates plus SYNC, with shadow/active config.
// Optional receiver-inhibit output is built when the macro PULSE_INHIBIT_EN is defined.
module pulse_seq_multi #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 16,
    parameter int ADDR_W     = 4,
    parameter int DEF_PERIOD = 1000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic              cfg_we_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [CNT_W-1:0]  cfg_wdata_i,
    input  logic              cfg_commit_i,
    output logic [NCH-1:0]    ch_out_o,
    output logic              sync_out_o,
    output logic              running_o,
    output logic              done_o
`ifdef PULSE_INHIBIT_EN
    ,
    output logic              inhib_o
`endif
);

    typedef struct packed {
        logic [CNT_W-1:0]          period;
        logic [CNT_W-1:0]          sync_w;
        logic [CNT_W-1:0]          n_per;
`ifdef PULSE_INHIBIT_EN
        logic [CNT_W-1:0]          guard;
`endif
        logic [NCH-1:0][CNT_W-1:0] delay;
        logic [NCH-1:0][CNT_W-1:0] width;
    } bank_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    function automatic bank_t bank_reset();
        bank_t b;
        b        = '0;
        b.period = CNT_W'(DEF_PERIOD);
        return b;
    endfunction

    bank_t            shadow_q, shadow_d, active_q;
    state_t           state_q;
    logic [CNT_W-1:0] pc_q, per_cnt_q, p_eff;
    logic [CNT_W:0]   pc_x;
    logic             commit_pend_q, wait_low_q, done_q, sync_q;
    logic [NCH-1:0]   ch_out_q, ch_d;
    logic             running, at_last, burst_end, copy_now, sync_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        shadow_d = shadow_q;
        if (cfg_we_i) begin
            case (cfg_addr_i)
                ADDR_W'(0): shadow_d.period = cfg_wdata_i;
                ADDR_W'(1): shadow_d.sync_w = cfg_wdata_i;
                ADDR_W'(2): shadow_d.n_per  = cfg_wdata_i;
`ifdef PULSE_INHIBIT_EN
                ADDR_W'(3): shadow_d.guard  = cfg_wdata_i;
`endif
                default: ;
            endcase
            for (int k = 0; k < NCH; k++) begin
                if (cfg_addr_i == ADDR_W'(4 + 2 * k)) shadow_d.delay[k] = cfg_wdata_i;
                if (cfg_addr_i == ADDR_W'(5 + 2 * k)) shadow_d.width[k] = cfg_wdata_i;
            end
        end
    end

    assign running   = (state_q != S_IDLE);
    assign p_eff     = (active_q.period < CNT_W'(2)) ? CNT_W'(2) : active_q.period;
    assign at_last   = running && (pc_q == p_eff - CNT_W'(1));
    assign burst_end = (active_q.n_per != '0) &&
                       (({1'b0, per_cnt_q} + (CNT_W+1)'(1)) == {1'b0, active_q.n_per});
    // Copy only at a period boundary while running so the active bank is stable within a period.
    assign copy_now  = (!running && cfg_commit_i) || (at_last && (commit_pend_q || cfg_commit_i));

    // Gate windows are compared one bit wider so delay+width can never wrap around.
    assign pc_x = {1'b0, pc_q};
    always_comb begin
        ch_d = '0;
        for (int k = 0; k < NCH; k++) begin
            ch_d[k] = running && ({1'b0, active_q.delay[k]} <= pc_x) &&
                      (pc_x < ({1'b0, active_q.delay[k]} + {1'b0, active_q.width[k]}));
        end
    end
    assign sync_d = running && (pc_q < active_q.sync_w);

    // NOTE: both config banks are small flop banks, so they are reset to defaults like any other state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            shadow_q      <= bank_reset();
            active_q      <= bank_reset();
            commit_pend_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            if (copy_now) begin
                active_q      <= shadow_d;
                commit_pend_q <= 1'b0;
            end else if (running && cfg_commit_i) begin
                commit_pend_q <= 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            per_cnt_q  <= '0;
            wait_low_q <= 1'b0;
            done_q     <= 1'b0;
            ch_out_q   <= '0;
            sync_q     <= 1'b0;
        end else begin
            ch_out_q <= ch_d;
            sync_q   <= sync_d;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    pc_q      <= '0;
                    per_cnt_q <= '0;
                    if (wait_low_q) begin
                        if (!enable_i) wait_low_q <= 1'b0;
                    end else if (enable_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN, S_STOP: begin
                    if (at_last) begin
                        pc_q      <= '0;
                        per_cnt_q <= per_cnt_q + CNT_W'(1);
                        if (burst_end) begin
                            done_q     <= 1'b1;
                            wait_low_q <= 1'b1;
                            state_q    <= S_IDLE;
                        end else if (state_q == S_STOP) begin
                            state_q <= S_IDLE;
                        end else if (!enable_i) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        pc_q <= pc_q + CNT_W'(1);
                        if (!enable_i) state_q <= S_STOP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ch_out_o   = ch_out_q;
    assign sync_out_o = sync_q;
    assign running_o  = running;
    assign done_o     = done_q;

`ifdef PULSE_INHIBIT_EN
    logic [CNT_W-1:0] guard_cnt_q;
    logic             inhib_q;

    // Any active gate reloads the guard countdown; inhibit stays high until it drains.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            guard_cnt_q <= '0;
            inhib_q     <= 1'b0;
        end else if (|ch_d) begin
            guard_cnt_q <= active_q.guard;
            inhib_q     <= 1'b1;
        end else if (guard_cnt_q != '0) begin
            guard_cnt_q <= guard_cnt_q - CNT_W'(1);
            inhib_q     <= 1'b1;
        end else begin
            inhib_q     <= 1'b0;
        end
    end

    assign inhib_o = inhib_q;
`endif

endmodule
